// File: rtl/encode_string_stream.sv
// encode_string_stream: serialises encode_string(S) = left_encode(8*len(S)) || S
// as a valid/ready byte stream and reports the encoded length for bytepad.
//
// Ports:
//   clk, rst_n  clock and asynchronous active-low reset
//   start       capture request, honoured only in IDLE
//   s_bytes     string S, byte 0 first (captured on start)
//   s_len       byte length of S, values above MAX_LEN saturate
//   out_data    registered output byte
//   out_valid   out_data valid
//   out_ready   downstream accepts the byte on this edge
//   out_last    high with the final byte of the encoding
//   enc_len     1 + n + s_len, held until the next capture
//   busy        high from capture until the done cycle
//   done        one-cycle pulse after the final byte is accepted
module encode_string_stream #(
    parameter int MAX_LEN = 8,
    parameter int LEN_W   = $clog2(MAX_LEN + 1),
    parameter int BITS_W  = LEN_W + 3,
    parameter int NB_MAX  = (BITS_W + 7) / 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [7:0]       s_bytes [0:MAX_LEN-1],
    input  logic [LEN_W-1:0] s_len,
    output logic [7:0]       out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_last,
    output logic [LEN_W+1:0] enc_len,
    output logic             busy,
    output logic             done
);

    localparam int PW  = NB_MAX * 8;
    localparam int SW  = MAX_LEN * 8;
    localparam int CW  = $clog2(NB_MAX + 1);
    localparam int ELW = LEN_W + 2;

    typedef enum logic [2:0] {IDLE, PREFIX, VALUE, DATA, DONE} state_t;

    state_t           state, state_n;
    logic [SW-1:0]    s_q, s_n;
    logic [LEN_W-1:0] len_q, len_n;
    logic [PW-1:0]    bits_q, bits_n;
    logic [CW-1:0]    n_q, n_n;
    logic [CW-1:0]    cnt, cnt_n;
    logic [LEN_W-1:0] idx, idx_n, idx_inc;
    logic [7:0]       data_n;
    logic             valid_n, last_n, busy_n, done_n;
    logic [ELW-1:0]   enc_n;

    logic [SW-1:0]    s_pack;
    logic [LEN_W-1:0] len_sat;
    logic [PW-1:0]    bits_c;
    logic [CW-1:0]    n_c;
    logic             accept;

    function automatic logic [7:0] value_byte(input logic [PW-1:0] v,
                                              input logic [CW-1:0] k);
        logic [PW-1:0] t;
        t = v >> (32'(k) * 8);
        return t[7:0];
    endfunction

    function automatic logic [7:0] data_byte(input logic [SW-1:0] v,
                                             input logic [LEN_W-1:0] k);
        logic [SW-1:0] t;
        t = v >> (32'(k) * 8);
        return t[7:0];
    endfunction

    // Capture-side arithmetic: saturated length, bit length and the
    // number of significant bytes of the bit length (never below 1).
    always_comb begin
        s_pack = '0;
        for (int i = 0; i < MAX_LEN; i++) begin
            s_pack[8*i +: 8] = s_bytes[i];
        end
        len_sat = (s_len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : s_len;
        bits_c  = PW'(len_sat) << 3;
        n_c     = CW'(1);
        for (int i = 1; i < NB_MAX; i++) begin
            if (bits_c[8*i +: 8] != 8'd0) begin
                n_c = CW'(i + 1);
            end
        end
    end

    assign accept  = out_valid && out_ready;
    assign idx_inc = idx + LEN_W'(1);

    always_comb begin
        state_n = state;
        s_n     = s_q;
        len_n   = len_q;
        bits_n  = bits_q;
        n_n     = n_q;
        cnt_n   = cnt;
        idx_n   = idx;
        data_n  = out_data;
        valid_n = out_valid;
        last_n  = out_last;
        busy_n  = busy;
        done_n  = 1'b0;
        enc_n   = enc_len;
        unique case (state)
            IDLE: begin
                if (start) begin
                    s_n     = s_pack;
                    len_n   = len_sat;
                    bits_n  = bits_c;
                    n_n     = n_c;
                    enc_n   = ELW'(n_c) + ELW'(len_sat) + ELW'(1);
                    data_n  = 8'(n_c);
                    valid_n = 1'b1;
                    last_n  = 1'b0;
                    busy_n  = 1'b1;
                    state_n = PREFIX;
                end
            end
            PREFIX: begin
                if (accept) begin
                    cnt_n   = n_q - CW'(1);
                    data_n  = value_byte(bits_q, n_q - CW'(1));
                    last_n  = (n_q == CW'(1)) && (len_q == '0);
                    state_n = VALUE;
                end
            end
            VALUE: begin
                if (accept) begin
                    if (cnt != '0) begin
                        cnt_n  = cnt - CW'(1);
                        data_n = value_byte(bits_q, cnt - CW'(1));
                        last_n = (cnt == CW'(1)) && (len_q == '0);
                    end else if (len_q == '0) begin
                        data_n  = 8'd0;
                        valid_n = 1'b0;
                        last_n  = 1'b0;
                        busy_n  = 1'b0;
                        done_n  = 1'b1;
                        state_n = DONE;
                    end else begin
                        idx_n   = '0;
                        data_n  = data_byte(s_q, '0);
                        last_n  = (len_q == LEN_W'(1));
                        state_n = DATA;
                    end
                end
            end
            DATA: begin
                if (accept) begin
                    if (idx_inc == len_q) begin
                        data_n  = 8'd0;
                        valid_n = 1'b0;
                        last_n  = 1'b0;
                        busy_n  = 1'b0;
                        done_n  = 1'b1;
                        state_n = DONE;
                    end else begin
                        idx_n  = idx_inc;
                        data_n = data_byte(s_q, idx_inc);
                        last_n = (idx_inc + LEN_W'(1) == len_q);
                    end
                end
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_q       <= '0;
            len_q     <= '0;
            bits_q    <= '0;
            n_q       <= '0;
            cnt       <= '0;
            idx       <= '0;
            out_data  <= 8'd0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            enc_len   <= '0;
        end else begin
            s_q       <= s_n;
            len_q     <= len_n;
            bits_q    <= bits_n;
            n_q       <= n_n;
            cnt       <= cnt_n;
            idx       <= idx_n;
            out_data  <= data_n;
            out_valid <= valid_n;
            out_last  <= last_n;
            busy      <= busy_n;
            done      <= done_n;
            enc_len   <= enc_n;
        end
    end

endmodule
